// File: rtl/spi_slave_frame_rx.sv
// spi_slave_frame_rx: oversampled SPI slave decoding 1-bit command + DATA_WIDTH payload frames
module spi_slave_frame_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int SYNC_STAGES = 2,
    parameter logic [DATA_WIDTH-1:0] IDLE_FILL = {DATA_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cs,
    input  logic                  sclk,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic                  busy,
    output logic                  frame_err,
    output logic                  tx_underrun
);
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, CMD, WR, RD, DONE} stateT;
    stateT state, stateNext;

    logic [SYNC_STAGES-1:0] csSync, sclkSync, mosiSync;
    logic                   csPrev, sclkPrev;
    logic                   csS, sclkS, mosiS;
    logic                   csRise, csFall, sclkRise, sclkFall;
    logic                   inFrame, abort, lastBit, rdLoad, wrDone, rdDone;
    logic [CW-1:0]          bitCnt;
    logic [DATA_WIDTH-1:0]  shiftReg, txHold;
    logic                   held;

    assign csS      = csSync[SYNC_STAGES-1];
    assign sclkS    = sclkSync[SYNC_STAGES-1];
    assign mosiS    = mosiSync[SYNC_STAGES-1];
    assign csRise   = csS & ~csPrev;
    assign csFall   = ~csS & csPrev;
    assign sclkRise = sclkS & ~sclkPrev;
    assign sclkFall = ~sclkS & sclkPrev;
    assign inFrame  = (state == CMD) || (state == WR) || (state == RD);
    assign abort    = inFrame && csRise;
    assign lastBit  = bitCnt == LAST_BIT;
    assign rdLoad   = (state == CMD) && sclkRise && !mosiS && !csRise;
    assign wrDone   = (state == WR) && sclkRise && lastBit && !csRise;
    assign rdDone   = (state == RD) && sclkRise && lastBit && !csRise;
    assign miso_oe  = state == RD;
    assign busy     = state != IDLE;
    assign tx_ready = ~held;

    // synchronise the pins to clk (idle levels on reset) and keep one-clk-old copies for edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csSync   <= '1;
            sclkSync <= '1;
            mosiSync <= '0;
            csPrev   <= 1'b1;
            sclkPrev <= 1'b1;
        end else begin
            csSync   <= {csSync[SYNC_STAGES-2:0], cs};
            sclkSync <= {sclkSync[SYNC_STAGES-2:0], sclk};
            mosiSync <= {mosiSync[SYNC_STAGES-2:0], mosi};
            csPrev   <= csS;
            sclkPrev <= sclkS;
        end
    end

    // frame state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= stateNext;
    end

    // next state: cs rise aborts any active frame, even on the final data edge
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    stateNext = csFall ? CMD : IDLE;
            CMD:     stateNext = csRise ? IDLE : sclkRise ? (mosiS ? WR : RD) : CMD;
            WR:      stateNext = csRise ? IDLE : (sclkRise && lastBit) ? DONE : WR;
            RD:      stateNext = csRise ? IDLE : (sclkRise && lastBit) ? DONE : RD;
            DONE:    stateNext = csRise ? IDLE : DONE;
            default: stateNext = IDLE;
        endcase
    end

    // bit counter and shared shift register: shift in on rise during WR, shift out on fall during RD
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bitCnt   <= '0;
            shiftReg <= '0;
        end else begin
            bitCnt   <= (state == IDLE && csFall) ? '0 :
                        ((state == WR || state == RD) && sclkRise) ? bitCnt + 1'b1 : bitCnt;
            shiftReg <= rdLoad ? (held ? txHold : IDLE_FILL) :
                        (state == WR && sclkRise) ? {shiftReg[DATA_WIDTH-2:0], mosiS} :
                        (state == RD && sclkFall) ? shiftReg << 1 : shiftReg;
        end
    end

    // miso idles high outside the read data phase and presents the MSB on each falling edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) miso <= 1'b1;
        else     miso <= (state != RD || rdDone || csRise) ? 1'b1 : sclkFall ? shiftReg[DATA_WIDTH-1] : miso;
    end

    // received word and single-cycle status pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            rx_data     <= wrDone ? {shiftReg[DATA_WIDTH-2:0], mosiS} : rx_data;
            rx_valid    <= wrDone;
            frame_err   <= abort;
            tx_underrun <= rdLoad && !held;
        end
    end

    // tx holding register: loads only when empty, emptied when a read frame takes it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held   <= 1'b0;
            txHold <= '0;
        end else begin
            held   <= held ? !rdLoad : tx_valid;
            txHold <= (tx_valid && !held) ? tx_data : txHold;
        end
    end
endmodule

// File: tb/tb_spi_slave_frame_rx.sv
// tb_spi_slave_frame_rx: directed frame-level bench for spi_slave_frame_rx
module tb_spi_slave_frame_rx;
    logic       clk = 1'b0, rst = 1'b1, cs = 1'b1, sclk = 1'b1, mosi = 1'b0, tx_valid = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       miso, miso_oe, rx_valid, tx_ready, busy, frame_err, tx_underrun;
    logic [7:0] rx_data;
    int         asserts = 0, failures = 0;
    int         rxCount = 0, errCount = 0, underCount = 0, oeCount = 0;
    logic [7:0] rxHist[$];

    spi_slave_frame_rx dut (
        .clk(clk), .rst(rst), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso), .miso_oe(miso_oe),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .busy(busy), .frame_err(frame_err), .tx_underrun(tx_underrun)
    );

    always #5 clk = ~clk;

    // pulse monitor sampled on the inactive edge
    always @(negedge clk) begin
        if (rx_valid) begin
            rxCount++;
            rxHist.push_back(rx_data);
        end
        if (frame_err) errCount++;
        if (tx_underrun) underCount++;
        if (miso_oe) oeCount++;
    end

    task automatic csDown();
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic sendBit(input logic b, output logic s);
        sclk = 1'b0;
        mosi = b;
        repeat (8) @(negedge clk);
        s = miso;
        sclk = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic csUp(input int gap);
        cs = 1'b1;
        mosi = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic doFrame(input logic cmd, input logic [7:0] d, input int n, input int gap, output logic [7:0] got);
        logic s;
        got = '0;
        csDown();
        sendBit(cmd, s);
        for (int i = 0; i < n; i++) begin
            sendBit(i < 8 ? d[7-i] : 1'b1, s);
            if (i < 8) got[7-i] = s;
        end
        csUp(gap);
    endtask

    task automatic loadTx(input logic [7:0] d);
        tx_data = d;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        asserts++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        asserts++; if (rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        asserts++; if (miso !== 1'b1) begin failures++; $display("FAIL reset_miso: got %b want 1", miso); end
        asserts++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL reset_miso_oe: got %b want 0", miso_oe); end
        asserts++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL reset_tx_ready: got %b want 1", tx_ready); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        asserts++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        asserts++; if (tx_underrun !== 1'b0) begin failures++; $display("FAIL reset_tx_underrun: got %b want 0", tx_underrun); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_write();
        int r0 = rxCount, e0 = errCount, o0 = oeCount;
        logic [7:0] got;
        doFrame(1'b1, 8'hA5, 8, 8, got);
        asserts++; if (rxCount - r0 != 1) begin failures++; $display("FAIL write_pulses: got %0d want 1", rxCount - r0); end
        asserts++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL write_rx_data: got %h want a5", rx_data); end
        asserts++; if (errCount - e0 != 0) begin failures++; $display("FAIL write_frame_err: got %0d want 0", errCount - e0); end
        asserts++; if (oeCount - o0 != 0) begin failures++; $display("FAIL write_miso_oe: got %0d cycles want 0", oeCount - o0); end
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after: got %b want 0", busy); end
    endtask

    task automatic test_read_tx();
        int r0 = rxCount, u0 = underCount, o0 = oeCount;
        logic [7:0] got;
        loadTx(8'h3C);
        asserts++; if (tx_ready !== 1'b0) begin failures++; $display("FAIL read_tx_ready_low: got %b want 0", tx_ready); end
        loadTx(8'h99);
        doFrame(1'b0, 8'h00, 8, 8, got);
        asserts++; if (got !== 8'h3C) begin failures++; $display("FAIL read_tx_word: got %h want 3c", got); end
        asserts++; if (underCount - u0 != 0) begin failures++; $display("FAIL read_tx_underrun: got %0d want 0", underCount - u0); end
        asserts++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL read_tx_ready_back: got %b want 1", tx_ready); end
        asserts++; if (oeCount - o0 == 0) begin failures++; $display("FAIL read_miso_oe_seen: got %0d cycles want >0", oeCount - o0); end
        asserts++; if (rxCount - r0 != 0) begin failures++; $display("FAIL read_no_rx_valid: got %0d want 0", rxCount - r0); end
        asserts++; if (miso !== 1'b1 || miso_oe !== 1'b0) begin failures++; $display("FAIL read_idle_after: got miso=%b oe=%b want 1/0", miso, miso_oe); end
    endtask

    task automatic test_read_empty();
        int u0 = underCount;
        logic [7:0] got;
        doFrame(1'b0, 8'h00, 8, 8, got);
        asserts++; if (got !== 8'hFF) begin failures++; $display("FAIL empty_fill_word: got %h want ff", got); end
        asserts++; if (underCount - u0 != 1) begin failures++; $display("FAIL empty_underrun: got %0d want 1", underCount - u0); end
    endtask

    task automatic test_abort();
        int r0 = rxCount, e0 = errCount;
        logic [7:0] got;
        doFrame(1'b1, 8'hF0, 4, 8, got);
        asserts++; if (errCount - e0 != 1) begin failures++; $display("FAIL abort_frame_err: got %0d want 1", errCount - e0); end
        asserts++; if (rxCount - r0 != 0) begin failures++; $display("FAIL abort_rx_valid: got %0d want 0", rxCount - r0); end
        asserts++; if (rx_data !== 8'hA5) begin failures++; $display("FAIL abort_rx_hold: got %h want a5", rx_data); end
    endtask

    task automatic test_overlength();
        int r0 = rxCount, e0 = errCount;
        logic [7:0] got;
        doFrame(1'b1, 8'h81, 12, 8, got);
        asserts++; if (rxCount - r0 != 1) begin failures++; $display("FAIL over_pulses: got %0d want 1", rxCount - r0); end
        asserts++; if (rx_data !== 8'h81) begin failures++; $display("FAIL over_rx_data: got %h want 81", rx_data); end
        asserts++; if (errCount - e0 != 0) begin failures++; $display("FAIL over_frame_err: got %0d want 0", errCount - e0); end
    endtask

    task automatic test_async_reset();
        logic s;
        loadTx(8'h11);
        csDown();
        sendBit(1'b0, s);
        loadTx(8'h55);
        sendBit(1'b1, s);
        sendBit(1'b0, s);
        sendBit(1'b1, s);
        asserts++; if (miso_oe !== 1'b1 || miso !== 1'b0 || tx_ready !== 1'b0) begin failures++; $display("FAIL arst_pre: got oe=%b miso=%b rdy=%b want 1/0/0", miso_oe, miso, tx_ready); end
        #2 rst = 1'b1;
        #1;
        asserts++; if (miso !== 1'b1) begin failures++; $display("FAIL arst_miso: got %b want 1", miso); end
        asserts++; if (miso_oe !== 1'b0) begin failures++; $display("FAIL arst_miso_oe: got %b want 0", miso_oe); end
        asserts++; if (tx_ready !== 1'b1) begin failures++; $display("FAIL arst_tx_ready: got %b want 1", tx_ready); end
        @(negedge clk);
        cs = 1'b1;
        sclk = 1'b1;
        mosi = 1'b0;
        rst = 1'b0;
        repeat (6) @(negedge clk);
        asserts++; if (busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int r0 = rxCount, base = rxHist.size();
        logic [7:0] got, h0, h1;
        doFrame(1'b1, 8'h01, 8, 3, got);
        doFrame(1'b1, 8'hFE, 8, 8, got);
        h0 = (rxHist.size() > base) ? rxHist[base] : 8'hxx;
        h1 = (rxHist.size() > base + 1) ? rxHist[base+1] : 8'hxx;
        asserts++; if (rxCount - r0 != 2) begin failures++; $display("FAIL b2b_pulses: got %0d want 2", rxCount - r0); end
        asserts++; if (h0 !== 8'h01) begin failures++; $display("FAIL b2b_first: got %h want 01", h0); end
        asserts++; if (h1 !== 8'hFE) begin failures++; $display("FAIL b2b_second: got %h want fe", h1); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_tx();
        test_read_empty();
        test_abort();
        test_overlength();
        test_async_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end
endmodule
